// File: rtl/imm_pkg.sv
// Shared immediate-type codes and RV64I base opcodes for the decode stage.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_SB   = 3'b010,
    IMM_U    = 3'b011,
    IMM_UJ   = 3'b100,
    IMM_NONE = 3'b101,
    IMM_ILL  = 3'b111
  } imm_type_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

endpackage

// File: rtl/imm_extract.sv
// Combinational opcode classifier and immediate builder; the immediate is
// assembled as a 32-bit signed value and then replicated out to XLEN.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  imm_type_e   kind;
  logic [31:0] raw;

  // Every legal opcode ends in 2'b11, so the default arm also catches instr[1:0]!=11.
  always_comb begin
    kind = IMM_ILL;
    raw  = '0;
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_MISCMEM, OPC_SYSTEM: begin
        kind = IMM_I;
        raw  = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        kind = IMM_S;
        raw  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        kind = IMM_SB;
        raw  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        kind = IMM_U;
        raw  = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        kind = IMM_UJ;
        raw  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_OP, OPC_OP32: begin
        kind = IMM_NONE;
      end
      default: begin
        kind = IMM_ILL;
      end
    endcase
  end

  assign imm_type  = kind;
  assign illegal   = (kind == IMM_ILL);
  assign imm[31:0] = raw;

  genvar gi;
  generate
    for (gi = 32; gi < XLEN; gi++) begin : g_sext
      assign imm[gi] = raw[31];
    end
  endgenerate

endmodule

// File: rtl/imm_decode_stage.sv
// One-deep registered decode stage: valid/ready pipeline register with flush
// around imm_extract, plus a saturating count of accepted illegal words.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [2:0]       out_imm_type,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [2:0]       dec_type;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;
  logic             accept;

  logic             valid_reg;
  logic [XLEN-1:0]  pc_reg;
  logic [2:0]       type_reg;
  logic [XLEN-1:0]  imm_reg;
  logic             illegal_reg;
  logic [CNT_W-1:0] cnt_reg;

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .instr    (in_instr),
    .imm_type (dec_type),
    .imm      (dec_imm),
    .illegal  (dec_illegal)
  );

  // Ready depends only on held state and downstream, never on in_valid.
  assign in_ready = !valid_reg || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      pc_reg      <= '0;
      type_reg    <= IMM_I;
      imm_reg     <= '0;
      illegal_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      if (flush) begin
        valid_reg <= 1'b0;
      end else if (accept) begin
        valid_reg <= 1'b1;
      end else if (out_ready) begin
        valid_reg <= 1'b0;
      end

      // Data only moves on accept, which keeps a stalled entry stable.
      if (accept) begin
        pc_reg      <= in_pc;
        type_reg    <= dec_type;
        imm_reg     <= dec_imm;
        illegal_reg <= dec_illegal;
      end

      if (accept && dec_illegal && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign out_valid    = valid_reg;
  assign out_pc       = pc_reg;
  assign out_imm_type = type_reg;
  assign out_imm      = imm_reg;
  assign out_illegal  = illegal_reg;
  assign illegal_cnt  = cnt_reg;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench: a 64-bit/16-bit-counter stage and a 32-bit/2-bit-counter
// stage share one stimulus stream and are both checked against one model.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_illegal;
  logic [63:0] out_pc, out_imm;
  logic [2:0]  out_imm_type;
  logic [15:0] illegal_cnt;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_pc32, out_imm32;
  logic [2:0]  out_imm_type32;
  logic [1:0]  illegal_cnt32;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm_type(out_imm_type), .out_imm(out_imm),
    .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  imm_decode_stage #(.XLEN(32), .CNT_W(2)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
    .out_pc(out_pc32), .out_imm_type(out_imm_type32), .out_imm(out_imm32),
    .out_illegal(out_illegal32), .illegal_cnt(illegal_cnt32)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  t;
    logic [63:0] imm;
    logic        ill;
    logic [15:0] c16;
    logic [1:0]  c2;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [15:0] cnt16_m = '0;
  logic [1:0]  cnt2_m  = '0;
  logic        held_m  = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference decode written from the field tables with signed arithmetic.
  task automatic ref_decode(input logic [31:0] w, output logic [2:0] t, output logic [63:0] imm);
    longint v;
    logic [6:0] opc;
    opc = w[6:0];
    v = 0;
    t = 3'b111;
    if (opc inside {7'h03, 7'h13, 7'h1B, 7'h67, 7'h0F, 7'h73}) begin
      t = 3'b000;
      v = longint'(w[31:20]);
      if (v >= 2048) v -= 4096;
    end else if (opc == 7'h23) begin
      t = 3'b001;
      v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
      if (v >= 2048) v -= 4096;
    end else if (opc == 7'h63) begin
      t = 3'b010;
      v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
        + longint'(w[11:8]) * 2;
      if (v >= 4096) v -= 8192;
    end else if (opc == 7'h37 || opc == 7'h17) begin
      t = 3'b011;
      v = longint'(w[31:12]) * 4096;
      if (w[31]) v -= 64'sd4294967296;
    end else if (opc == 7'h6F) begin
      t = 3'b100;
      v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
        + longint'(w[30:21]) * 2;
      if (v >= 1048576) v -= 2097152;
    end else if (opc == 7'h33 || opc == 7'h3B) begin
      t = 3'b101;
    end
    imm = v;
  endtask

  // One cycle of stimulus; expected entries are pushed when the model accepts.
  task automatic step(input logic v, input logic [31:0] w, input logic r,
                      input logic f, input logic rs);
    logic  acc;
    exp_t  e;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_instr  = w;
    in_pc     = {$urandom, $urandom};
    out_ready = r;
    flush     = f;
    rst       = rs;
    @(negedge clk);
    #1;
    acc = !rs && !f && v && (!held_m || r);
    if (rs) begin
      cnt16_m = '0;
      cnt2_m  = '0;
      held_m  = 1'b0;
    end else begin
      if (acc) begin
        e.instr = w;
        e.pc    = in_pc;
        ref_decode(w, e.t, e.imm);
        e.ill   = (e.t == 3'b111);
        if (e.ill && cnt16_m != 16'hFFFF) cnt16_m = cnt16_m + 1;
        if (e.ill && cnt2_m != 2'd3) cnt2_m = cnt2_m + 1;
        e.c16 = cnt16_m;
        e.c2  = cnt2_m;
        q.push_back(e);
      end
      held_m = f ? 1'b0 : (acc ? 1'b1 : (r ? 1'b0 : held_m));
    end
  endtask

  // Monitor: compares the held entry every cycle, so stalls must hold stable.
  logic [15:0] last16 = '0;
  logic [1:0]  last2  = '0;
  logic        rst_prev = 1'b0;

  initial begin
    logic exp_v;
    exp_t e;
    forever begin
      @(negedge clk);
      exp_v = (q.size() != 0);
      chk("in_ready64", {63'b0, in_ready}, {63'b0, !exp_v || out_ready});
      chk("in_ready32", {63'b0, in_ready32}, {63'b0, !exp_v || out_ready});
      chk("out_valid64", {63'b0, out_valid}, {63'b0, exp_v});
      chk("out_valid32", {63'b0, out_valid32}, {63'b0, exp_v});
      if (rst_prev) begin
        chk("rst_pc64", out_pc, 64'd0);
        chk("rst_type64", {61'b0, out_imm_type}, 64'd0);
        chk("rst_imm64", out_imm, 64'd0);
        chk("rst_ill64", {63'b0, out_illegal}, 64'd0);
        chk("rst_cnt64", {48'b0, illegal_cnt}, 64'd0);
        chk("rst_pc32", {32'b0, out_pc32}, 64'd0);
        chk("rst_imm32", {32'b0, out_imm32}, 64'd0);
        chk("rst_cnt32", {62'b0, illegal_cnt32}, 64'd0);
      end
      if (exp_v) begin
        e = q[0];
        chk("pc64", out_pc, e.pc);
        chk("type64", {61'b0, out_imm_type}, {61'b0, e.t});
        chk("imm64", out_imm, e.imm);
        chk("ill64", {63'b0, out_illegal}, {63'b0, e.ill});
        chk("cnt64", {48'b0, illegal_cnt}, {48'b0, e.c16});
        chk("pc32", {32'b0, out_pc32}, {32'b0, e.pc[31:0]});
        chk("type32", {61'b0, out_imm_type32}, {61'b0, e.t});
        chk("imm32", {32'b0, out_imm32}, {32'b0, e.imm[31:0]});
        chk("ill32", {63'b0, out_illegal32}, {63'b0, e.ill});
        chk("cnt32", {62'b0, illegal_cnt32}, {62'b0, e.c2});
      end else begin
        chk("cnt64_idle", {48'b0, illegal_cnt}, {48'b0, last16});
        chk("cnt32_idle", {62'b0, illegal_cnt32}, {62'b0, last2});
      end
      if (rst) begin
        q.delete();
        last16 = '0;
        last2  = '0;
      end else if (exp_v && (out_ready || flush)) begin
        last16 = e.c16;
        last2  = e.c2;
        $display("txn instr=%08h type=%0d imm=%016h %s", e.instr, e.t, e.imm,
                 out_ready ? "consumed" : "flushed");
        void'(q.pop_front());
      end
      rst_prev = rst;
    end
  end

  logic [31:0] opc_tab [13] = '{32'h03, 32'h13, 32'h1B, 32'h67, 32'h0F, 32'h73, 32'h23,
                                32'h63, 32'h37, 32'h17, 32'h6F, 32'h33, 32'h3B};

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0:       return w;
      1:       return 32'h0000_0000;
      default: return {w[31:7], opc_tab[$urandom_range(0, 12)][6:0]};
    endcase
  endfunction

  initial begin
    logic [31:0] dir [6] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3,
                             32'h800000B7, 32'h001000EF, 32'h00000033};
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // Directed format sweep, one instruction per cycle.
    for (int i = 0; i < 6; i++) step(1, dir[i], 1, 0, 0);
    step(0, 0, 1, 0, 0);
    // Backpressure: three stalled cycles, then release.
    step(1, 32'h00A00113, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h00B00193, 0, 0, 0);
    step(1, 32'h00B00193, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    // Ten-deep back-to-back stream.
    for (int i = 0; i < 10; i++) step(1, rand_instr(), 1, 0, 0);
    // Flush an illegal input while an entry is held.
    step(1, 32'h00100093, 0, 0, 0);
    step(1, 32'h0000007F, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(1, 32'h0000007F, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    // Illegal encodings drive the 2-bit counter into saturation.
    step(1, 32'h0000007F, 1, 0, 0);
    step(1, 32'h00000000, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'h0000007F, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    // Reset while stalled with a held entry.
    step(1, 32'h800000B7, 1, 0, 0);
    step(1, 32'h00000013, 0, 0, 0);
    step(1, 32'h00000013, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 32'h800000B7, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
